// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer giving two masters
// one-access-per-cycle use of a single-port data memory.
module dmem_arbiter #(
    parameter int ADDR_W     = 6,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [31:0]       a_wdata_i,
    output logic              a_gnt_o,
    output logic [31:0]       a_rdata_o,
    output logic              a_rvalid_o,

    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [31:0]       b_wdata_i,
    output logic              b_gnt_o,
    output logic [31:0]       b_rdata_o,
    output logic              b_rvalid_o,

    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_memwrite_o,
    output logic              mem_memread_o,
    input  logic [31:0]       mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   prio, prio_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            prio  <= FIRST_PRIO;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        mem_address_o  = '0;
        mem_wdata_o    = '0;
        mem_memwrite_o = 1'b0;
        mem_memread_o  = 1'b0;
        a_gnt_o        = 1'b0;
        b_gnt_o        = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_req_i && b_req_i)
                    state_nxt = prio ? SERVE_B : SERVE_A;
                else if (a_req_i)
                    state_nxt = SERVE_A;
                else if (b_req_i)
                    state_nxt = SERVE_B;
                else
                    state_nxt = IDLE;
            end
            SERVE_A: begin
                a_gnt_o        = 1'b1;
                mem_address_o  = a_addr_i;
                mem_wdata_o    = a_wdata_i;
                mem_memwrite_o = a_we_i & ~rst_i;
                mem_memread_o  = ~a_we_i;
                prio_nxt       = 1'b1;
                // a_req_i still belongs to this access, so only B counts
                state_nxt      = b_req_i ? SERVE_B : IDLE;
            end
            SERVE_B: begin
                b_gnt_o        = 1'b1;
                mem_address_o  = b_addr_i;
                mem_wdata_o    = b_wdata_i;
                mem_memwrite_o = b_we_i & ~rst_i;
                mem_memread_o  = ~b_we_i;
                prio_nxt       = 1'b0;
                state_nxt      = a_req_i ? SERVE_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rdata_o  <= '0;
            a_rvalid_o <= 1'b0;
            b_rdata_o  <= '0;
            b_rvalid_o <= 1'b0;
        end else begin
            a_rvalid_o <= a_gnt_o & ~a_we_i;
            b_rvalid_o <= b_gnt_o & ~b_we_i;
            if (a_gnt_o && !a_we_i)
                a_rdata_o <= mem_rdata_i;
            if (b_gnt_o && !b_we_i)
                b_rdata_o <= mem_rdata_i;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural
// single-port memory attached to the memory side.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_req_i, a_we_i;
    logic [5:0]  a_addr_i;
    logic [31:0] a_wdata_i;
    logic        a_gnt_o, a_rvalid_o;
    logic [31:0] a_rdata_o;
    logic        b_req_i, b_we_i;
    logic [5:0]  b_addr_i;
    logic [31:0] b_wdata_i;
    logic        b_gnt_o, b_rvalid_o;
    logic [31:0] b_rdata_o;
    logic [5:0]  mem_address_o;
    logic [31:0] mem_wdata_o;
    logic        mem_memwrite_o, mem_memread_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    logic [31:0] mem [64];

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(6), .FIRST_PRIO(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_we_i(a_we_i),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_gnt_o(a_gnt_o), .a_rdata_o(a_rdata_o),
        .a_rvalid_o(a_rvalid_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i),
        .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_gnt_o(b_gnt_o), .b_rdata_o(b_rdata_o),
        .b_rvalid_o(b_rvalid_o),
        .mem_address_o(mem_address_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_memwrite_o(mem_memwrite_o),
        .mem_memread_o(mem_memread_o),
        .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (mem_memwrite_o)
            mem[mem_address_o] <= mem_wdata_o;

    assign mem_rdata_i = mem[mem_address_o];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".a_gnt"}, a_gnt_o, 0);
        chk({tag, ".b_gnt"}, b_gnt_o, 0);
        chk({tag, ".a_rvalid"}, a_rvalid_o, 0);
        chk({tag, ".b_rvalid"}, b_rvalid_o, 0);
        chk({tag, ".a_rdata"}, a_rdata_o, 0);
        chk({tag, ".b_rdata"}, b_rdata_o, 0);
        chk({tag, ".memwrite"}, mem_memwrite_o, 0);
        chk({tag, ".memread"}, mem_memread_o, 0);
        chk({tag, ".busy"}, busy_o, 0);
    endtask

    // Solo port-A access: request, grant cycle, then return in the
    // cycle after the grant with the request dropped.
    task automatic a_op(input string tag, input logic we,
                        input logic [5:0] addr,
                        input logic [31:0] wd);
        a_req_i = 1'b1; a_we_i = we;
        a_addr_i = addr; a_wdata_i = wd;
        tick();
        chk({tag, ".gnt"}, a_gnt_o, 1);
        chk({tag, ".addr"}, mem_address_o, 32'(addr));
        chk({tag, ".we"}, mem_memwrite_o, 32'(we));
        a_req_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        a_req_i = 0; a_we_i = 0; a_addr_i = 0; a_wdata_i = 0;
        b_req_i = 0; b_we_i = 0; b_addr_i = 0; b_wdata_i = 0;

        // reset state, then held reset
        tick(); tick();
        chk_idle_outputs("rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outputs("rst_hold");
        end
        rst_i = 1'b0;

        // A write 5 then read 5 with one idle bubble
        a_req_i = 1; a_we_i = 1; a_addr_i = 6'd5;
        a_wdata_i = 32'hDEADBEEF;
        #1;
        chk("wr5.c0.gnt", a_gnt_o, 0);
        tick();
        chk("wr5.c1.gnt", a_gnt_o, 1);
        chk("wr5.c1.memwrite", mem_memwrite_o, 1);
        chk("wr5.c1.addr", mem_address_o, 5);
        chk("wr5.c1.wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("wr5.c1.busy", busy_o, 1);
        tick();
        a_we_i = 0;
        #1;
        chk("rd5.c2.gnt", a_gnt_o, 0);
        chk("rd5.c2.busy", busy_o, 0);
        tick();
        chk("rd5.c3.gnt", a_gnt_o, 1);
        chk("rd5.c3.memread", mem_memread_o, 1);
        chk("rd5.c3.memwrite", mem_memwrite_o, 0);
        tick();
        a_req_i = 0;
        chk("rd5.c4.rvalid", a_rvalid_o, 1);
        chk("rd5.c4.rdata", a_rdata_o, 32'hDEADBEEF);
        chk("rd5.c4.b_rvalid", b_rvalid_o, 0);
        tick();
        chk("rd5.c5.rvalid", a_rvalid_o, 0);
        chk("rd5.c5.rdata_hold", a_rdata_o, 32'hDEADBEEF);

        // both ports every cycle from reset: A,B,A,B
        rst_i = 1;
        tick();
        rst_i = 0;
        a_req_i = 1; a_we_i = 1; a_addr_i = 6'd1;
        a_wdata_i = 32'h11111111;
        b_req_i = 1; b_we_i = 0; b_addr_i = 6'd5;
        #1;
        chk("rr.d0.a_gnt", a_gnt_o, 0);
        chk("rr.d0.b_gnt", b_gnt_o, 0);
        tick();
        chk("rr.d1.a_gnt", a_gnt_o, 1);
        chk("rr.d1.b_gnt", b_gnt_o, 0);
        chk("rr.d1.memwrite", mem_memwrite_o, 1);
        tick();
        chk("rr.d2.b_gnt", b_gnt_o, 1);
        chk("rr.d2.a_gnt", a_gnt_o, 0);
        chk("rr.d2.memwrite", mem_memwrite_o, 0);
        chk("rr.d2.addr", mem_address_o, 5);
        tick();
        chk("rr.d3.a_gnt", a_gnt_o, 1);
        chk("rr.d3.memwrite", mem_memwrite_o, 1);
        chk("rr.d3.b_rvalid", b_rvalid_o, 1);
        chk("rr.d3.b_rdata", b_rdata_o, 32'hDEADBEEF);
        tick();
        chk("rr.d4.b_gnt", b_gnt_o, 1);
        chk("rr.d4.memwrite", mem_memwrite_o, 0);
        chk("rr.d4.b_rvalid", b_rvalid_o, 0);
        a_req_i = 0; b_req_i = 0;
        tick();
        chk("rr.d5.b_rvalid", b_rvalid_o, 1);
        chk("rr.d5.busy", busy_o, 0);
        chk("rr.mem1", mem[1], 32'h11111111);

        // B preloads 63, then reads it against a streaming A
        b_req_i = 1; b_we_i = 1; b_addr_i = 6'd63;
        b_wdata_i = 32'h0BADF00D;
        tick();
        chk("bw63.gnt", b_gnt_o, 1);
        chk("bw63.memwrite", mem_memwrite_o, 1);
        b_req_i = 0;
        tick();
        chk("bw63.rvalid", b_rvalid_o, 0);
        a_req_i = 1; a_we_i = 0; a_addr_i = 6'd5;
        b_req_i = 1; b_we_i = 0; b_addr_i = 6'd63;
        tick();
        chk("str.f1.a_gnt", a_gnt_o, 1);
        chk("str.f1.b_gnt", b_gnt_o, 0);
        tick();
        chk("str.f2.b_gnt", b_gnt_o, 1);
        chk("str.f2.addr", mem_address_o, 63);
        chk("str.f2.a_rvalid", a_rvalid_o, 1);
        chk("str.f2.a_rdata", a_rdata_o, 32'hDEADBEEF);
        b_req_i = 0;
        tick();
        chk("str.f3.b_rvalid", b_rvalid_o, 1);
        chk("str.f3.b_rdata", b_rdata_o, 32'h0BADF00D);
        chk("str.f3.a_gnt", a_gnt_o, 1);
        a_req_i = 0;
        tick();
        chk("str.f4.a_rvalid", a_rvalid_o, 1);
        chk("str.f4.busy", busy_o, 0);

        // write on a reset edge must be suppressed
        a_op("init10", 1'b1, 6'd10, 32'h0);
        a_req_i = 1; a_we_i = 1; a_addr_i = 6'd10;
        a_wdata_i = 32'h12345678;
        tick();
        rst_i = 1;
        #1;
        chk("rstwr.gnt", a_gnt_o, 1);
        chk("rstwr.memwrite", mem_memwrite_o, 0);
        tick();
        rst_i = 0; a_req_i = 0;
        chk("rstwr.busy", busy_o, 0);
        chk("rstwr.gnt_after", a_gnt_o, 0);
        chk("rstwr.mem10", mem[10], 32'h0);
        a_op("rd10", 1'b0, 6'd10, 32'h0);
        chk("rd10.rvalid", a_rvalid_o, 1);
        chk("rd10.rdata", a_rdata_o, 32'h0);

        // address extremes do not alias
        a_op("w63", 1'b1, 6'd63, 32'hA5A5A5A5);
        chk("w63.rvalid", a_rvalid_o, 0);
        a_op("w0", 1'b1, 6'd0, 32'h5A5A5A5A);
        a_op("r63", 1'b0, 6'd63, 32'h0);
        chk("r63.rvalid", a_rvalid_o, 1);
        chk("r63.rdata", a_rdata_o, 32'hA5A5A5A5);
        a_op("r0", 1'b0, 6'd0, 32'h0);
        chk("r0.rvalid", a_rvalid_o, 1);
        chk("r0.rdata", a_rdata_o, 32'h5A5A5A5A);
        a_op("w1", 1'b1, 6'd1, 32'h77777777);
        chk("w1.rdata_hold", a_rdata_o, 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port data memory (32-bit words, combinational read, write on clock edge).
- Port A is the core load/store path; port B is a secondary master (debug/loader).
- Grants one access per cycle with a round-robin tie-break, registers read data per port, and guarantees no memory write on a reset edge.

Parameters:
ADDR_W, 6, word-address width driven to memory
FIRST_PRIO, 0, port favoured after reset (0 = A, 1 = B)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
a_req_i  in  1  port A request; held high with stable addr/we/wdata until a_gnt_o
a_we_i  in  1  port A: 1 = write, 0 = read
a_addr_i  in  ADDR_W  port A word address
a_wdata_i  in  32  port A write data
a_gnt_o  out  1  port A access performed this cycle
a_rdata_o  out  32  port A registered read data
a_rvalid_o  out  1  one-cycle pulse: a_rdata_o valid
b_req_i, b_we_i, b_addr_i, b_wdata_i, b_gnt_o, b_rdata_o, b_rvalid_o  same as A for port B
mem_address_o  out  ADDR_W  to memory address
mem_wdata_o  out  32  to memory write data
mem_memwrite_o  out  1  to memory write enable
mem_memread_o  out  1  to memory read enable
mem_rdata_i  in  32  from memory read data (combinational)
busy_o  out  1  high when state is not IDLE

Behaviour:
- State machine: IDLE, SERVE_A, SERVE_B. Priority pointer `prio` is 1 bit (0 = A next).
- Reset (rst_i = 1 at an edge):
  - state = IDLE; prio = FIRST_PRIO.
  - a/b_rdata_o = 0; a/b_rvalid_o = 0.
  - a/b_gnt_o = 0 in the following cycle.
- IDLE:
  - Memory outputs: address 0, wdata 0, memwrite 0, memread 0. No grants.
  - Next state: only A requesting -> SERVE_A; only B -> SERVE_B; both -> the port selected by prio; neither -> IDLE.
- SERVE_x:
  - Combinational drive: mem_address_o = x_addr_i, mem_wdata_o = x_wdata_i.
  - mem_memwrite_o = x_we_i & ~rst_i; mem_memread_o = ~x_we_i.
  - x_gnt_o = 1 for exactly this cycle.
- Write: commits at the rising edge that ends SERVE_x. The requester may drop req or present a new transaction in the next cycle.
- Read:
  - x_rdata_o <= mem_rdata_i at the edge ending SERVE_x.
  - x_rvalid_o = 1 in the following cycle only. Read latency is 1 cycle after gnt.
  - x_rdata_o holds its value until the next read completes for that port.
- Writes never assert rvalid and never change rdata_o.
- Leaving SERVE_x:
  - prio <= other port.
  - Next state decision ignores x_req_i, because it still belongs to the completed transaction.
  - Other port requesting -> SERVE_other (back-to-back, no bubble); otherwise -> IDLE.
- Consequences of that rule:
  - The same port issuing back-to-back requests sees one IDLE bubble: at most one access per 2 cycles when alone.
  - Alternating A/B requests get 100% memory utilisation.
  - Neither port waits more than one foreign transaction (starvation-free).
- Combinational paths:
  - gnt depends only on state; there is no req -> gnt combinational path.
  - Memory address/data depend combinationally on the selected port inputs only.
- Requester dropping req before gnt: undefined and not required to be handled. If the FSM is already in SERVE_x, the access is still performed with the current inputs.
- Reset mid-transaction:
  - A write in SERVE_x on the reset edge is suppressed (memwrite gated by rst_i).
  - A read on that edge produces no rvalid.
  - State returns to IDLE.
- busy_o = (state != IDLE).

Test Plan:
- Reset check: after reset, all gnt/rvalid = 0, rdata = 0, memwrite = memread = 0, busy = 0, then hold reset 3 cycles -> outputs remain at reset values.
- A writes 0xDEADBEEF @5, then A reads @5 -> gnt on cycle 1, IDLE bubble, gnt on cycle 3, a_rvalid_o high cycle 4 with a_rdata_o = 0xDEADBEEF; b_rvalid_o stays 0.
- A and B both request every cycle (A writes, B reads) from reset with FIRST_PRIO = 0 -> grants A, B, A, B with no bubbles; mem_memwrite_o toggles 1,0,1,0.
- B holds a read @63 while A streams requests -> B granted no later than the 2nd cycle after raising req; b_rdata_o equals memory[63].
- A write of 0x12345678 @10 in SERVE_A with rst_i asserted that cycle -> mem_memwrite_o = 0; subsequent read @10 returns the prior contents (0x0 after init write of 0).
- Address wrap: A writes 0xA5A5A5A5 @63, then @0 writes 0x5A5A5A5A -> reads return the respective values; no aliasing.
